signature_deserializer: RTL and testbench

SIGNATURE_DESERIALIZER -- requirements
Module: signature_deserializer

---
 rtl/signature_deserializer.sv | 64 ++++++
 tb/tb_signature_deserializer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/signature_deserializer.sv
// rtl/signature_deserializer.sv - MSB-first serial-to-byte deserializer with frame index and XOR checksum
module signature_deserializer #(
    parameter  int FRAME_BYTES = 32,
    localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_en,
    input  logic             align,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic [IDX_W-1:0] byte_idx,
    output logic             frame_end,
    output logic [7:0]       checksum
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt;
    logic [IDX_W-1:0] frame_cnt;
    logic [7:0]       next_byte;

    assign next_byte = {shift_reg[6:0], din};

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= 8'd0;
            bit_cnt    <= 3'd0;
            frame_cnt  <= '0;
            byte_out   <= 8'd0;
            byte_valid <= 1'b0;
            byte_idx   <= '0;
            frame_end  <= 1'b0;
            checksum   <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            frame_end  <= 1'b0;
            if (align) begin
                // Clearing frame_cnt is what restarts the checksum on the next byte.
                frame_cnt <= '0;
                if (din_en) begin
                    shift_reg <= next_byte;
                    bit_cnt   <= 3'd1;
                end else begin
                    bit_cnt   <= 3'd0;
                end
            end else if (din_en) begin
                shift_reg <= next_byte;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_out   <= next_byte;
                    byte_valid <= 1'b1;
                    byte_idx   <= frame_cnt;
                    frame_end  <= (frame_cnt == LAST_IDX);
                    checksum   <= (frame_cnt == '0) ? next_byte : (checksum ^ next_byte);
                    frame_cnt  <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_signature_deserializer.sv
// tb/tb_signature_deserializer.sv - directed self-checking bench for signature_deserializer
module tb_signature_deserializer;

    localparam int FB = 32;

    logic       clk;
    logic       reset;
    logic       din;
    logic       din_en;
    logic       align;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [4:0] byte_idx;
    logic       frame_end;
    logic [7:0] checksum;

    int checks = 0;
    int errors = 0;
    int exp_idx = 0;
    logic [7:0] exp_ck = 8'd0;
    logic [255:0] msg;

    signature_deserializer #(.FRAME_BYTES(FB)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_en     (din_en),
        .align      (align),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_idx   (byte_idx),
        .frame_end  (frame_end),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic en, input logic al);
        din    = d;
        din_en = en;
        align  = al;
        @(posedge clk);
        #1;
        din_en = 1'b0;
        align  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset   = 1'b0;
        exp_idx = 0;
        exp_ck  = 8'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_byte_out"},   32'(byte_out),   32'h0);
        chk({tag, "_byte_valid"}, 32'(byte_valid), 32'h0);
        chk({tag, "_byte_idx"},   32'(byte_idx),   32'h0);
        chk({tag, "_frame_end"},  32'(frame_end),  32'h0);
        chk({tag, "_checksum"},   32'(checksum),   32'h0);
    endtask

    // Sends one byte back-to-back and checks the pulse lands exactly after the 8th bit.
    task automatic send_byte(input string tag, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            step(b[i], 1'b1, 1'b0);
            if (i != 0) chk({tag, "_gap_valid"}, 32'(byte_valid), 32'h0);
        end
        exp_ck = (exp_idx == 0) ? b : (exp_ck ^ b);
        chk({tag, "_valid"},     32'(byte_valid), 32'h1);
        chk({tag, "_byte_out"},  32'(byte_out),   32'(b));
        chk({tag, "_byte_idx"},  32'(byte_idx),   32'(exp_idx));
        chk({tag, "_frame_end"}, 32'(frame_end),  32'(exp_idx == FB - 1));
        chk({tag, "_checksum"},  32'(checksum),   32'(exp_ck));
        exp_idx = (exp_idx + 1) % FB;
    endtask

    initial begin
        reset  = 1'b1;
        din    = 1'b0;
        din_en = 1'b0;
        align  = 1'b0;
        msg    = "Luke Vassallo Tiny Tapeout 2023.";

        // Reset with align and din_en high: reset wins.
        do_reset();
        chk_zero("reset");

        // Single byte 0x4C, then hold.
        send_byte("single", 8'h4C);
        chk("single_hard_ck", 32'(checksum), 32'h4C);
        step(1'b1, 1'b0, 1'b0);
        chk("single_idle_valid", 32'(byte_valid), 32'h0);
        chk("single_hold_out",   32'(byte_out),   32'h4C);
        chk("single_hold_ck",    32'(checksum),   32'h4C);

        // Stall of 3 cycles after 4 bits of 0x4C.
        do_reset();
        step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("stall_valid", 32'(byte_valid), 32'h0);
        end
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        chk("stall_early_valid", 32'(byte_valid), 32'h0);
        step(1'b0, 1'b1, 1'b0);
        chk("stall_valid_pulse", 32'(byte_valid), 32'h1);
        chk("stall_byte_out",    32'(byte_out),   32'h4C);
        step(1'b0, 1'b0, 1'b0);
        chk("stall_after_valid", 32'(byte_valid), 32'h0);

        // Full 32-byte frame sent continuously.
        do_reset();
        for (int k = 0; k < FB; k++) begin
            send_byte("frame", msg[255 - 8*k -: 8]);
            if (k == 0) chk("frame_first", 32'(byte_out), 32'h4C);
        end
        chk("frame_last_out", 32'(byte_out),  32'h2E);
        chk("frame_last_idx", 32'(byte_idx),  32'd31);
        chk("frame_last_end", 32'(frame_end), 32'h1);

        // Checksum restart at frame wrap.
        do_reset();
        for (int k = 0; k < FB - 1; k++) send_byte("wrap_zero", 8'h00);
        send_byte("wrap_a5", 8'hA5);
        chk("wrap_a5_ck",  32'(checksum),  32'hA5);
        chk("wrap_a5_end", 32'(frame_end), 32'h1);
        send_byte("wrap_3c", 8'h3C);
        chk("wrap_3c_idx", 32'(byte_idx), 32'h0);
        chk("wrap_3c_ck",  32'(checksum), 32'h3C);

        // Reset after 5 bits of 0xFF.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        do_reset();
        chk_zero("midreset");
        send_byte("after_reset", 8'h81);
        chk("after_reset_idx", 32'(byte_idx), 32'h0);
        chk("after_reset_ck",  32'(checksum), 32'h81);

        // Align with din_en after 3 bits; align bit is MSB of 0xC3.
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("align_hold_out", 32'(byte_out), 32'h81);
        chk("align_hold_ck",  32'(checksum), 32'h81);
        step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("align_early_valid", 32'(byte_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("align_valid",    32'(byte_valid), 32'h1);
        chk("align_byte_out", 32'(byte_out),   32'hC3);
        chk("align_byte_idx", 32'(byte_idx),   32'h0);
        chk("align_checksum", 32'(checksum),   32'hC3);

        // Align landing on the 8th bit discards the byte.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("align8_valid", 32'(byte_valid), 32'h0);
        chk("align8_out",   32'(byte_out),   32'hC3);
        step(1'b0, 1'b0, 1'b1);
        chk("align_idle_valid", 32'(byte_valid), 32'h0);
        exp_idx = 0;
        send_byte("post_align", 8'h5A);
        chk("post_align_ck", 32'(checksum), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
